// File: rtl/xadc_drp_scheduler.sv
// Purpose: round-robin arbiter that shares one XADC DRP read port among 4 requesters.
// Latency: req seen in IDLE at cycle 0 -> drp_den at cycle 1 -> rd_valid one cycle after drp_drdy (or after TIMEOUT WAIT cycles).
// Backpressure: none; req is a level sampled only in IDLE, held requests wait for a later IDLE.
//
// Ports:
//   clk_1MHz, rst_n        clock (also XADC dclk_in) and async active-low reset
//   req[3:0], req_addr     per-requester read request and 7-bit DRP address at [7i+6:7i]
//   gnt[3:0]               one-hot grant, held from grant through the DONE cycle
//   rd_valid[3:0]          one-cycle completion pulse to the granted requester
//   rd_data[11:0], rd_err  drp_do[15:4] result / timeout flag, held until the next completion
//   busy                   high whenever the scheduler is not IDLE
//   drp_den, drp_daddr     DRP enable and address towards the XADC (reads only; dwe/di tied low outside)
//   drp_do, drp_drdy       DRP read data and data-ready from the XADC
`timescale 1ns/1ps
module xadc_drp_scheduler #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk_1MHz,
    input  logic        rst_n,
    input  logic [3:0]  req,
    input  logic [27:0] req_addr,
    output logic [3:0]  gnt,
    output logic [3:0]  rd_valid,
    output logic [11:0] rd_data,
    output logic        rd_err,
    output logic        busy,
    output logic        drp_den,
    output logic [6:0]  drp_daddr,
    input  logic [15:0] drp_do,
    input  logic        drp_drdy
);

    localparam int CW = $clog2(TIMEOUT);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_DONE
    } state_t;

    state_t        state;
    logic [1:0]    ptr;       // last winner; search starts one past it
    logic [1:0]    win;       // winner of the transaction in flight
    logic [CW-1:0] cnt;       // WAIT cycles elapsed, saturates at TIMEOUT-1

    logic          rr_found;
    logic [1:0]    rr_idx;
    logic [1:0]    cand;
    logic [6:0]    rr_addr;

    // Round-robin search: ptr+1, ptr+2, ptr+3, then ptr itself last.
    always_comb begin
        rr_found = 1'b0;
        rr_idx   = ptr;
        cand     = ptr;
        for (int i = 1; i <= 4; i++) begin
            cand = ptr + 2'(i);
            if (!rr_found && req[cand]) begin
                rr_found = 1'b1;
                rr_idx   = cand;
            end
        end
    end

    always_comb begin
        rr_addr = req_addr[6:0];
        case (rr_idx)
            2'd0: rr_addr = req_addr[6:0];
            2'd1: rr_addr = req_addr[13:7];
            2'd2: rr_addr = req_addr[20:14];
            2'd3: rr_addr = req_addr[27:21];
            default: rr_addr = req_addr[6:0];
        endcase
    end

    always_ff @(posedge clk_1MHz or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            ptr       <= 2'd3;
            win       <= 2'd0;
            cnt       <= '0;
            gnt       <= '0;
            rd_valid  <= '0;
            rd_data   <= '0;
            rd_err    <= 1'b0;
            busy      <= 1'b0;
            drp_den   <= 1'b0;
            drp_daddr <= '0;
        end else begin
            // Single-cycle pulses default low every cycle.
            rd_valid <= '0;
            drp_den  <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (rr_found) begin
                        gnt       <= 4'b0001 << rr_idx;
                        win       <= rr_idx;
                        drp_daddr <= rr_addr;
                        drp_den   <= 1'b1;
                        busy      <= 1'b1;
                        state     <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    cnt   <= '0;
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    // drdy is checked first so it wins over a same-cycle timeout.
                    if (drp_drdy) begin
                        rd_data  <= drp_do[15:4];
                        rd_err   <= 1'b0;
                        rd_valid <= gnt;
                        state    <= S_DONE;
                    end else if (cnt == CNT_LAST) begin
                        rd_data  <= '0;
                        rd_err   <= 1'b1;
                        rd_valid <= gnt;
                        state    <= S_DONE;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                S_DONE: begin
                    ptr   <= win;
                    gnt   <= '0;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
